// File: rtl/clarvi_pio_in.sv
// clarvi_pio_in -- Avalon-MM input PIO for clarvi_soc.
// Synchronises (and optionally debounces) external pins, latches selected
// edges into a write-1-to-clear capture register and raises a maskable,
// registered level interrupt.
//
// Build option: define CLARVI_PIO_IN_DEBOUNCE_EN to include the per-pin
// debounce counters. Without it, DATA follows the synchronised pins every
// cycle and DEBOUNCE_CYCLES has no effect.
//
// Register map (word addresses, bits above WIDTH read as 0):
//   0 DATA  RO     debounced pin levels
//   1 MASK  RW     interrupt enable per pin
//   2 EDGE  R/W1C  captured edges
//   3 RAW   RO     synchronised pins, not debounced
module clarvi_pio_in #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CAPTURE_RISE    = 1,
  parameter int CAPTURE_FALL    = 1
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [WIDTH-1:0] pio_in,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq
);

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_MASK = 2'd1,
    ADDR_EDGE = 2'd2,
    ADDR_RAW  = 2'd3
  } reg_addr_e;

  // Reject parameter values the hardware cannot honour.
  if (WIDTH < 1 || WIDTH > 32 || DEBOUNCE_CYCLES < 2) begin : g_bad_param
    $error("clarvi_pio_in: WIDTH must be 1..32 and DEBOUNCE_CYCLES >= 2");
  end

  localparam logic [WIDTH-1:0] RISE_EN = (CAPTURE_RISE != 0) ? '1 : '0;
  localparam logic [WIDTH-1:0] FALL_EN = (CAPTURE_FALL != 0) ? '1 : '0;

  // Synchroniser and arming state
  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [1:0]       arm_cnt_q;
  logic             armed_q;

  // Level / edge / register state
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] data_dly_q;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edge_clr;
  logic             irq_q;
  logic [31:0]      readdata_q, readdata_d;

  reg_addr_e        addr;
  logic [WIDTH-1:0] wdata;
  logic             unused_wdata;

  assign addr  = reg_addr_e'(avs_address);
  assign wdata = avs_writedata[WIDTH-1:0];
  // Upper write-data bits have no storage behind them.
  assign unused_wdata = ^avs_writedata;

  // Two-flop synchroniser for the asynchronous pins.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its source, giving a true 2-stage chain.
      sync1_q <= pio_in;
      sync2_q <= sync1_q;
    end
  end

  // Arm edge capture once the synchroniser has been flushed after reset.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      arm_cnt_q <= '0;
      armed_q   <= 1'b0;
    end else if (!armed_q) begin
      if (arm_cnt_q == 2'd2) begin
        armed_q <= 1'b1;
      end else begin
        arm_cnt_q <= arm_cnt_q + 2'd1;
      end
    end
  end

`ifdef CLARVI_PIO_IN_DEBOUNCE_EN
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_prev_q;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Per-pin debounce: count while the synchronised level differs from DATA
  // and is steady; accept it once the count reaches the last value.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch
    // is inferred.
    data_d = data_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (!armed_q) begin
        data_d[i] = sync2_q[i];
      end else if (sync2_q[i] != data_q[i] && sync2_q[i] == sync_prev_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          data_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounce counters and the previous synchronised level.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync_prev_q <= '0;
      // NOTE: the counter array is a handful of flops, not a RAM, so it is
      // cleared on reset to discard any level change in progress.
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync_prev_q <= sync2_q;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
`else
  // Without debounce DATA is simply a third flop behind the synchroniser.
  always_comb begin
    data_d = sync2_q;
  end
`endif

  // DATA and its one-cycle-delayed copy; before arming both track the pins
  // so power-up settling never looks like an edge.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      data_q     <= '0;
      data_dly_q <= '0;
    end else begin
      data_q     <= data_d;
      data_dly_q <= armed_q ? data_q : sync2_q;
    end
  end

  // Edge detection and register-file next state; a new edge beats a W1C.
  always_comb begin
    edge_set = '0;
    if (armed_q) begin
      edge_set = ((data_q & ~data_dly_q) & RISE_EN) |
                 ((~data_q & data_dly_q) & FALL_EN);
    end

    edge_clr = '0;
    if (avs_write && addr == ADDR_EDGE) begin
      edge_clr = wdata;
    end
    edge_d = (edge_q & ~edge_clr) | edge_set;

    mask_d = mask_q;
    if (avs_write && addr == ADDR_MASK) begin
      mask_d = wdata;
    end
  end

  // Read mux; the output register holds its value when no read is issued.
  always_comb begin
    readdata_d = readdata_q;
    if (avs_read) begin
      readdata_d = '0;
      unique case (addr)
        ADDR_DATA: readdata_d[WIDTH-1:0] = data_q;
        ADDR_MASK: readdata_d[WIDTH-1:0] = mask_q;
        ADDR_EDGE: readdata_d[WIDTH-1:0] = edge_q;
        ADDR_RAW:  readdata_d[WIDTH-1:0] = sync2_q;
        default:   readdata_d = '0;
      endcase
    end
  end

  // Software-visible registers, registered interrupt and read data.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      mask_q     <= '0;
      edge_q     <= '0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      irq_q      <= |(edge_q & mask_q);
      readdata_q <= readdata_d;
    end
  end

  assign avs_readdata = readdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_clarvi_pio_in.sv
// Directed self-checking bench for clarvi_pio_in (WIDTH=8, DEBOUNCE_CYCLES=16).
// Read expectations go through a scoreboard queue: pushed when the read is
// issued, popped when the registered read data is sampled on the next
// falling edge. Works for both builds of CLARVI_PIO_IN_DEBOUNCE_EN.
module tb_clarvi_pio_in;

  localparam int WIDTH = 8;
  localparam int DEB   = 16;
`ifdef CLARVI_PIO_IN_DEBOUNCE_EN
  localparam int  LAT   = 2 + DEB + 1;  // pin change -> DATA update, in edges
  localparam bit  DB_ON = 1'b1;
`else
  localparam int  LAT   = 3;
  localparam bit  DB_ON = 1'b0;
`endif

  logic             clk_clk = 1'b0;
  logic             reset_reset_n;
  logic [WIDTH-1:0] pio_in;
  logic [1:0]       avs_address;
  logic             avs_read;
  logic             avs_write;
  logic [31:0]      avs_writedata;
  logic [31:0]      avs_readdata;
  logic             irq;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];

  clarvi_pio_in #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DEB),
    .CAPTURE_RISE   (1),
    .CAPTURE_FALL   (1)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .pio_in       (pio_in),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata (avs_readdata),
    .irq          (irq)
  );

  always #5 clk_clk = ~clk_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pop_cmp();
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      check(tag_q.pop_front(), avs_readdata, exp_q.pop_front());
    end
  endtask

  // Entered just after a falling edge; leaves just after the next one.
  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string t);
    avs_address = a;
    avs_read    = 1'b1;
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(negedge clk_clk);
    avs_read = 1'b0;
    pop_cmp();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(negedge clk_clk);
    avs_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_clk);
  endtask

  initial begin
    reset_reset_n = 1'b0;
    pio_in        = '0;
    avs_address   = '0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;

    // ---- reset state ----
    @(negedge clk_clk);
    check("rst_readdata", avs_readdata, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    idle(2);
    reset_reset_n = 1'b1;
    idle(5);
    rd(2'd0, 32'h00, "rst_data");
    rd(2'd1, 32'h00, "rst_mask");
    rd(2'd2, 32'h00, "rst_edge");
    rd(2'd3, 32'h00, "rst_raw");

    // ---- 1: pin0 rise, DATA latency checked every cycle ----
    pio_in      = 8'h01;
    avs_address = 2'd0;
    avs_read    = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) begin
      exp_q.push_back((k - 1 >= LAT) ? 32'h01 : 32'h00);
      tag_q.push_back($sformatf("t1_data_k%0d", k));
      @(negedge clk_clk);
      pop_cmp();
      check("t1_irq_masked", {31'd0, irq}, 32'h0);
    end
    avs_read = 1'b0;
    idle(40 - LAT - 1);
    rd(2'd2, 32'h01, "t1_edge");
    rd(2'd0, 32'h01, "t1_data_hold");
    rd(2'd2, 32'h01, "t1_edge_read_no_clear");
    check("t1_irq_end", {31'd0, irq}, 32'h0);

    // ---- 2: 10-cycle low glitch on pin0 ----
    wr(2'd2, 32'h01);
    wr(2'd1, 32'h01);
    idle(2);
    check("t2_irq_pre", {31'd0, irq}, 32'h0);
    pio_in = 8'h00;
    idle(3);
    rd(2'd3, 32'h00, "t2_raw_pulse");
    idle(6);
    pio_in = 8'h01;
    idle(30);
    rd(2'd3, 32'h01, "t2_raw_back");
    rd(2'd0, 32'h01, "t2_data");
    rd(2'd2, DB_ON ? 32'h00 : 32'h01, "t2_edge");
    check("t2_irq", {31'd0, irq}, DB_ON ? 32'h0 : 32'h1);
    wr(2'd2, 32'h01);
    idle(2);
    check("t2_irq_cleared", {31'd0, irq}, 32'h0);

    // ---- 3: masked rise -> irq one cycle after EDGE ----
    pio_in = 8'h00;
    idle(LAT + 4);
    wr(2'd2, 32'h01);
    idle(2);
    check("t3_irq_pre", {31'd0, irq}, 32'h0);
    pio_in      = 8'h01;
    avs_address = 2'd2;
    avs_read    = 1'b1;
    for (int k = 1; k <= LAT + 3; k++) begin
      exp_q.push_back((k - 1 >= LAT + 1) ? 32'h01 : 32'h00);
      tag_q.push_back($sformatf("t3_edge_k%0d", k));
      @(negedge clk_clk);
      pop_cmp();
      check($sformatf("t3_irq_k%0d", k), {31'd0, irq}, (k >= LAT + 2) ? 32'h1 : 32'h0);
    end
    avs_read = 1'b0;
    wr(2'd2, 32'h00);
    rd(2'd2, 32'h01, "t3_w0_no_effect");
    check("t3_irq_after_w0", {31'd0, irq}, 32'h1);
    wr(2'd2, 32'h01);
    check("t3_irq_same_cycle", {31'd0, irq}, 32'h1);
    @(negedge clk_clk);
    check("t3_irq_cleared", {31'd0, irq}, 32'h0);
    rd(2'd2, 32'h00, "t3_edge_cleared");

    // ---- 4: W1C collides with new edge on bit 3; register map corners ----
    wr(2'd1, 32'hFFFF_FF08);
    rd(2'd1, 32'h08, "t4_mask_upper_ignored");
    pio_in = 8'h09;
    idle(LAT);
    wr(2'd2, 32'h08);
    @(negedge clk_clk);
    check("t4_irq_set_wins", {31'd0, irq}, 32'h1);
    rd(2'd2, 32'h08, "t4_edge_set_wins");
    avs_address   = 2'd1;
    avs_writedata = 32'h01;
    avs_read      = 1'b1;
    avs_write     = 1'b1;
    exp_q.push_back(32'h08);
    tag_q.push_back("t4_rw_prewrite");
    @(negedge clk_clk);
    avs_read  = 1'b0;
    avs_write = 1'b0;
    pop_cmp();
    rd(2'd1, 32'h01, "t4_mask_written");
    wr(2'd0, 32'hFF);
    wr(2'd3, 32'hFF);
    rd(2'd0, 32'h09, "t4_data_ro");
    rd(2'd3, 32'h09, "t4_raw_ro");
    check("t4_irq_mask_cleared", {31'd0, irq}, 32'h0);

    // ---- 5: pins high through reset release; reset mid-debounce ----
    reset_reset_n = 1'b0;
    pio_in        = 8'hFF;
    @(negedge clk_clk);
    check("t5_rst_readdata", avs_readdata, 32'h0);
    check("t5_rst_irq", {31'd0, irq}, 32'h0);
    idle(2);
    reset_reset_n = 1'b1;
    idle(10);
    rd(2'd2, 32'h00, "t5_edge_no_powerup");
    rd(2'd0, 32'hFF, "t5_data_settled");
    rd(2'd3, 32'hFF, "t5_raw");
    rd(2'd1, 32'h00, "t5_mask");
    check("t5_irq", {31'd0, irq}, 32'h0);
    pio_in = 8'h00;
    idle(5);
    reset_reset_n = 1'b0;
    idle(2);
    reset_reset_n = 1'b1;
    idle(5);
    rd(2'd0, 32'h00, "t5_mid_data");
    rd(2'd1, 32'h00, "t5_mid_mask");
    rd(2'd2, 32'h00, "t5_mid_edge");
    rd(2'd3, 32'h00, "t5_mid_raw");
    idle(LAT + 5);
    rd(2'd0, 32'h00, "t5_pending_discarded");

    // ---- 6: pin2 change, single-cycle reads around the update ----
    pio_in = 8'h04;
    idle(LAT - 1);
    rd(2'd0, 32'h00, "t6_data_before");
    rd(2'd0, 32'h04, "t6_data_after");
    idle(3);
    rd(2'd2, 32'h04, "t6_edge");
    check("t6_irq", {31'd0, irq}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
